// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive framer.
package hdlc_pkg;

   localparam logic [7:0] HDLC_FLAG       = 8'h7E;
   localparam int         HDLC_ABORT_ONES = 7;
   // Abort as seen in the shift register: the leading 0 sits in bit 0 (oldest).
   localparam logic [7:0] HDLC_ABORT      = {{HDLC_ABORT_ONES{1'b1}}, {(8 - HDLC_ABORT_ONES){1'b0}}};
   localparam int         MAX_BYTES_DEF   = 128;

   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } rx_state_t;

endpackage

// File: rtl/hdlc_rx_flag_det.sv
// Line shift register with flag/abort pattern matching.
// The match stage (_p1) lets the framer act on a flag in the same cycle that
// the registered detect pulse (_p2) becomes visible.
module hdlc_rx_flag_det
   import hdlc_pkg::*;
(
   input  logic Clk,
   input  logic clr,
   input  logic rxBit,
   output logic tapBit_p0,
   output logic flagHit_p1,
   output logic abortHit_p1,
   output logic flagDet_p2,
   output logic abortDet_p2
);

   logic [7:0] rxSr_p0;

   // Shift the line bit in at the MSB; the bit falling out of bit 0 is the 8-bit delayed data tap
   always_ff @(posedge Clk) begin
      if (clr) begin
         rxSr_p0   <= 8'h00;
         tapBit_p0 <= 1'b0;
      end else begin
         rxSr_p0   <= {rxBit, rxSr_p0[7:1]};
         tapBit_p0 <= rxSr_p0[0];
      end
   end

   // Pattern match on the current shift register contents
   always_ff @(posedge Clk) begin
      if (clr) begin
         flagHit_p1  <= 1'b0;
         abortHit_p1 <= 1'b0;
      end else begin
         flagHit_p1  <= (rxSr_p0 == HDLC_FLAG);
         abortHit_p1 <= (rxSr_p0 == HDLC_ABORT);
      end
   end

   // Registered one-cycle detect pulses
   always_ff @(posedge Clk) begin
      if (clr) begin
         flagDet_p2  <= 1'b0;
         abortDet_p2 <= 1'b0;
      end else begin
         flagDet_p2  <= flagHit_p1;
         abortDet_p2 <= abortHit_p1;
      end
   end

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort handling, zero destuffing and LSB-first
// byte assembly for the Rx buffer write path.
// Optional byte limit: define HDLC_RX_OVERFLOW_EN to enable Rx_Overflow.
module hdlc_rx_framer
   import hdlc_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF
)(
   input  logic       Clk,
   input  logic       Rst,
   input  logic       RxEN,
   input  logic       Rx,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_ValidFrame,
   output logic       Rx_AbortSignal,
   output logic [7:0] Rx_Data,
   output logic       Rx_WrBuff,
   output logic       Rx_EoF,
   output logic       Rx_FrameError,
   output logic [7:0] Rx_FrameSize,
   output logic       Rx_Overflow
);

   function automatic logic [7:0] satInc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [2:0] satInc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   logic       clr;
   logic       tapBit_p0, flagHit_p1, abortHit_p1, flagDet_p2, abortDet_p2;
   rx_state_t  state, stateNext;
   logic [2:0] bitCnt, onesCnt, skipCnt;
   logic [7:0] byteCnt, shiftByte, newByte;
   logic       dataTake, stuffDrop, byteDone, strobeOk;

   assign clr = !Rst || !RxEN;

   hdlc_rx_flag_det u_flagDet (
      .Clk         (Clk),
      .clr         (clr),
      .rxBit       (Rx),
      .tapBit_p0   (tapBit_p0),
      .flagHit_p1  (flagHit_p1),
      .abortHit_p1 (abortHit_p1),
      .flagDet_p2  (flagDet_p2),
      .abortDet_p2 (abortDet_p2)
   );

   assign Rx_FlagDetect  = flagDet_p2;
   assign Rx_AbortDetect = abortDet_p2;
   assign Rx_ValidFrame  = (state == FRAME);
   assign newByte        = {tapBit_p0, shiftByte[7:1]};
   assign byteDone       = dataTake && (bitCnt == 3'd7);

   // Frame state register
   always_ff @(posedge Clk) begin
      if (clr) state <= IDLE;
      else     state <= stateNext;
   end

   // Open on a flag; leave only on an abort (closing flags reopen in place)
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (flagHit_p1)  stateNext = FRAME;
         FRAME:   if (abortDet_p2) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Classify the tap bit: flag/abort bits are skipped, stuffed zeros dropped, the rest is data
   always_comb begin
      dataTake  = 1'b0;
      stuffDrop = 1'b0;
      if (!flagHit_p1 && !abortHit_p1 && (skipCnt == 3'd0) && (state == FRAME)) begin
         if (!tapBit_p0 && (onesCnt == 3'd5)) stuffDrop = 1'b1;
         else                                 dataTake  = 1'b1;
      end
   end

   // Byte assembly register, LSB first
   always_ff @(posedge Clk) begin
      if (dataTake) shiftByte <= newByte;
   end

   // Frame counters and output strobes
   always_ff @(posedge Clk) begin
      if (clr) begin
         bitCnt         <= 3'd0;
         onesCnt        <= 3'd0;
         skipCnt        <= 3'd0;
         byteCnt        <= 8'd0;
         Rx_Data        <= 8'h00;
         Rx_WrBuff      <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_FrameSize   <= 8'd0;
         Rx_AbortSignal <= 1'b0;
      end else begin
         Rx_WrBuff      <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_AbortSignal <= abortDet_p2 && (state == FRAME);
         if (flagHit_p1 || abortHit_p1) begin
            if (flagHit_p1 && (state == FRAME) && ((byteCnt != 8'd0) || (bitCnt != 3'd0))) begin
               Rx_EoF        <= 1'b1;
               Rx_FrameError <= (bitCnt != 3'd0);
            end
            if (flagHit_p1 && (state == IDLE)) Rx_FrameSize <= 8'd0;
            // The remaining seven pattern bits still have to drain past the tap
            bitCnt  <= 3'd0;
            onesCnt <= 3'd0;
            byteCnt <= 8'd0;
            skipCnt <= 3'd7;
         end else if (skipCnt != 3'd0) begin
            skipCnt <= skipCnt - 3'd1;
         end else if (stuffDrop) begin
            onesCnt <= 3'd0;
         end else if (dataTake) begin
            onesCnt <= tapBit_p0 ? satInc3(onesCnt) : 3'd0;
            bitCnt  <= bitCnt + 3'd1;
            if (byteDone && strobeOk) begin
               Rx_WrBuff    <= 1'b1;
               Rx_Data      <= newByte;
               byteCnt      <= satInc8(byteCnt);
               Rx_FrameSize <= satInc8(byteCnt);
            end
         end
      end
   end

`ifdef HDLC_RX_OVERFLOW_EN
   localparam logic [7:0] BYTE_LIMIT = 8'(MAX_BYTES);

   logic overflow;

   assign strobeOk    = !overflow && (byteCnt != BYTE_LIMIT);
   assign Rx_Overflow = overflow;

   // Overflow latches on the first byte past the limit and clears on any flag or abort
   always_ff @(posedge Clk) begin
      if (clr)                             overflow <= 1'b0;
      else if (flagHit_p1 || abortHit_p1)  overflow <= 1'b0;
      else if (byteDone && !strobeOk)      overflow <= 1'b1;
   end
`else
   assign strobeOk    = 1'b1;
   assign Rx_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_framer.sv
`timescale 1ns/1ps
module tb_hdlc_rx_framer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       RxEN = 1'b0;
   logic       Rx = 1'b1;
   logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
   logic [7:0] Rx_Data;
   logic       Rx_WrBuff, Rx_EoF, Rx_FrameError;
   logic [7:0] Rx_FrameSize;
   logic       Rx_Overflow;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int flagCnt, abortDetCnt, abortSigCnt, wrCnt, eofCnt, ferrCnt, eofNoFlag, ovfSeen;
   int flagCyc, abortDetCyc, abortSigCyc;
   logic [7:0] firstData, lastData, sizeAtEof;
   int txOnes = 0;

   hdlc_rx_framer dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .RxEN           (RxEN),
      .Rx             (Rx),
      .Rx_FlagDetect  (Rx_FlagDetect),
      .Rx_AbortDetect (Rx_AbortDetect),
      .Rx_ValidFrame  (Rx_ValidFrame),
      .Rx_AbortSignal (Rx_AbortSignal),
      .Rx_Data        (Rx_Data),
      .Rx_WrBuff      (Rx_WrBuff),
      .Rx_EoF         (Rx_EoF),
      .Rx_FrameError  (Rx_FrameError),
      .Rx_FrameSize   (Rx_FrameSize),
      .Rx_Overflow    (Rx_Overflow)
   );

   always #5 Clk = ~Clk;

   // Event recorder, sampled just after each rising edge
   always @(posedge Clk) begin
      #1;
      cyc++;
      if (Rx_FlagDetect)  begin flagCnt++;     flagCyc = cyc;     end
      if (Rx_AbortDetect) begin abortDetCnt++; abortDetCyc = cyc; end
      if (Rx_AbortSignal) begin abortSigCnt++; abortSigCyc = cyc; end
      if (Rx_WrBuff) begin
         if (wrCnt == 0) firstData = Rx_Data;
         lastData = Rx_Data;
         wrCnt++;
      end
      if (Rx_EoF) begin
         eofCnt++;
         sizeAtEof = Rx_FrameSize;
         if (!Rx_FlagDetect) eofNoFlag++;
      end
      if (Rx_FrameError) begin
         ferrCnt++;
         if (!Rx_EoF) eofNoFlag++;
      end
      if (Rx_Overflow) ovfSeen++;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic clearCounts();
      flagCnt = 0; abortDetCnt = 0; abortSigCnt = 0; wrCnt = 0; eofCnt = 0;
      ferrCnt = 0; eofNoFlag = 0; ovfSeen = 0;
      flagCyc = -1; abortDetCyc = -1; abortSigCyc = -1;
      firstData = 8'h00; lastData = 8'h00; sizeAtEof = 8'h00;
   endtask

   task automatic sendBit(input logic b);
      @(negedge Clk);
      Rx = b;
   endtask

   task automatic sendRaw(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) sendBit(v[i]);
   endtask

   task automatic sendFlag();
      sendRaw(16'h007E, 8);
      txOnes = 0;
   endtask

   // Transmit-side bit stuffing: a 0 is inserted after five data ones
   task automatic sendByte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         sendBit(b[i]);
         if (b[i]) begin
            txOnes++;
            if (txOnes == 5) begin
               sendBit(1'b0);
               txOnes = 0;
            end
         end else begin
            txOnes = 0;
         end
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Disable/enable the receiver, let idle ones settle, then clear the recorder
   task automatic startLine();
      @(negedge Clk);
      RxEN = 1'b0;
      Rx   = 1'b1;
      @(negedge Clk);
      RxEN = 1'b1;
      for (int i = 0; i < 13; i++) sendBit(1'b1);
      clearCounts();
   endtask

   task automatic test_reset();
      Rst = 1'b0; RxEN = 1'b1; Rx = 1'b1;
      repeat (3) @(posedge Clk);
      #2;
      if ({Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl: got %b want 00000000", {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow});
      end
      checks++;
      if (Rx_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", Rx_Data); end
      checks++;
      if (Rx_FrameSize !== 8'h00) begin errors++; $display("FAIL reset_size: got %0d want 0", Rx_FrameSize); end
      checks++;
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   task automatic test_flag_timing();
      int nFinal;
      startLine();
      sendRaw(16'h007E, 7);
      sendBit(1'b0);
      @(posedge Clk);
      #2;
      nFinal = cyc;
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      idleCycles(2);
      if (flagCyc - nFinal !== 2) begin errors++; $display("FAIL flag_latency: got %0d want 2", flagCyc - nFinal); end
      checks++;
      if (flagCnt !== 1) begin errors++; $display("FAIL flag_pulse_count: got %0d want 1", flagCnt); end
      checks++;
      if (Rx_ValidFrame !== 1'b1) begin errors++; $display("FAIL flag_valid: got %b want 1", Rx_ValidFrame); end
      checks++;
      if (wrCnt !== 0) begin errors++; $display("FAIL flag_no_wr: got %0d want 0", wrCnt); end
      checks++;
   endtask

   task automatic test_single_byte();
      startLine();
      sendFlag();
      sendByte(8'hA5);
      sendFlag();
      sendFlag();
      idleCycles(4);
      if (wrCnt !== 1) begin errors++; $display("FAIL byte_wr_count: got %0d want 1", wrCnt); end
      checks++;
      if (lastData !== 8'hA5) begin errors++; $display("FAIL byte_data: got %h want a5", lastData); end
      checks++;
      if (eofCnt !== 1) begin errors++; $display("FAIL byte_eof: got %0d want 1", eofCnt); end
      checks++;
      if (ferrCnt !== 0) begin errors++; $display("FAIL byte_ferr: got %0d want 0", ferrCnt); end
      checks++;
      if (sizeAtEof !== 8'd1) begin errors++; $display("FAIL byte_size: got %0d want 1", sizeAtEof); end
      checks++;
      if (eofNoFlag !== 0) begin errors++; $display("FAIL byte_eof_align: got %0d want 0", eofNoFlag); end
      checks++;
   endtask

   task automatic test_stuffing();
      startLine();
      sendFlag();
      sendRaw(16'h005F, 9);
      sendFlag();
      sendFlag();
      idleCycles(4);
      if (wrCnt !== 1) begin errors++; $display("FAIL stuff_wr_count: got %0d want 1", wrCnt); end
      checks++;
      if (lastData !== 8'h3F) begin errors++; $display("FAIL stuff_data: got %h want 3f", lastData); end
      checks++;
      if ({eofCnt, ferrCnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL stuff_eof: got eof=%0d ferr=%0d want 1/0", eofCnt, ferrCnt); end
      checks++;
   endtask

   task automatic test_abort();
      startLine();
      sendFlag();
      sendByte(8'h12);
      sendRaw(16'h00FE, 8);
      for (int i = 0; i < 10; i++) sendBit(1'b1);
      if (abortDetCnt !== 1) begin errors++; $display("FAIL abort_detect_count: got %0d want 1", abortDetCnt); end
      checks++;
      if (abortSigCnt !== 1) begin errors++; $display("FAIL abort_signal_count: got %0d want 1", abortSigCnt); end
      checks++;
      if (abortSigCyc - abortDetCyc !== 1) begin errors++; $display("FAIL abort_signal_lag: got %0d want 1", abortSigCyc - abortDetCyc); end
      checks++;
      if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", Rx_ValidFrame); end
      checks++;
      if (eofCnt !== 0) begin errors++; $display("FAIL abort_no_eof: got %0d want 0", eofCnt); end
      checks++;
      if ({wrCnt, lastData} !== {32'd1, 8'h12}) begin errors++; $display("FAIL abort_byte: got wr=%0d data=%h want 1/12", wrCnt, lastData); end
      checks++;
      clearCounts();
      sendRaw(16'h00FE, 8);
      for (int i = 0; i < 5; i++) sendBit(1'b1);
      if (abortDetCnt !== 1) begin errors++; $display("FAIL idle_abort_detect: got %0d want 1", abortDetCnt); end
      checks++;
      if (abortSigCnt !== 0) begin errors++; $display("FAIL idle_abort_signal: got %0d want 0", abortSigCnt); end
      checks++;
   endtask

   task automatic test_frame_error();
      startLine();
      sendFlag();
      sendByte(8'hA5);
      sendRaw(16'h0009, 4);
      sendFlag();
      sendFlag();
      idleCycles(4);
      if (eofCnt !== 1) begin errors++; $display("FAIL ferr_eof: got %0d want 1", eofCnt); end
      checks++;
      if (ferrCnt !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", ferrCnt); end
      checks++;
      if ({wrCnt, lastData} !== {32'd1, 8'hA5}) begin errors++; $display("FAIL ferr_byte: got wr=%0d data=%h want 1/a5", wrCnt, lastData); end
      checks++;
      if (eofNoFlag !== 0) begin errors++; $display("FAIL ferr_align: got %0d want 0", eofNoFlag); end
      checks++;
   endtask

   task automatic test_back_to_back();
      startLine();
      sendFlag();
      sendFlag();
      sendRaw(16'h003F, 7);
      sendByte(8'h81);
      sendFlag();
      sendByte(8'h42);
      sendFlag();
      sendFlag();
      idleCycles(4);
      if (flagCnt !== 6) begin errors++; $display("FAIL b2b_flags: got %0d want 6", flagCnt); end
      checks++;
      if (eofCnt !== 2) begin errors++; $display("FAIL b2b_eof: got %0d want 2", eofCnt); end
      checks++;
      if ({wrCnt, firstData, lastData} !== {32'd2, 8'h81, 8'h42}) begin
         errors++; $display("FAIL b2b_bytes: got wr=%0d first=%h last=%h want 2/81/42", wrCnt, firstData, lastData);
      end
      checks++;
      if ({ferrCnt, sizeAtEof} !== {32'd0, 8'd1}) begin errors++; $display("FAIL b2b_ferr_size: got ferr=%0d size=%0d want 0/1", ferrCnt, sizeAtEof); end
      checks++;
   endtask

   task automatic test_byte_limit();
      startLine();
      sendFlag();
      for (int i = 0; i < 129; i++) sendByte(8'(i));
      sendFlag();
      sendFlag();
      idleCycles(4);
`ifdef HDLC_RX_OVERFLOW_EN
      if (wrCnt !== 128) begin errors++; $display("FAIL ovf_wr_count: got %0d want 128", wrCnt); end
      checks++;
      if (ovfSeen < 1) begin errors++; $display("FAIL ovf_set: got %0d cycles want >=1", ovfSeen); end
      checks++;
      if (Rx_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", Rx_Overflow); end
      checks++;
      if ({sizeAtEof, lastData} !== {8'd128, 8'h7F}) begin errors++; $display("FAIL ovf_size: got size=%0d last=%h want 128/7f", sizeAtEof, lastData); end
      checks++;
`else
      if (wrCnt !== 129) begin errors++; $display("FAIL limit_wr_count: got %0d want 129", wrCnt); end
      checks++;
      if (ovfSeen !== 0) begin errors++; $display("FAIL limit_no_ovf: got %0d want 0", ovfSeen); end
      checks++;
      if ({sizeAtEof, firstData, lastData} !== {8'd129, 8'h00, 8'h80}) begin
         errors++; $display("FAIL limit_size: got size=%0d first=%h last=%h want 129/00/80", sizeAtEof, firstData, lastData);
      end
      checks++;
`endif
   endtask

   task automatic test_mid_clear(input logic useRst);
      startLine();
      sendFlag();
      sendByte(8'h5A);
      sendByte(8'h3C);
      sendRaw(16'h0005, 3);
      @(posedge Clk);
      #2;
      if ({Rx_ValidFrame, Rx_FrameSize} !== {1'b1, 8'd1}) begin
         errors++; $display("FAIL clear_pre(%0d): got valid=%b size=%0d want 1/1", useRst, Rx_ValidFrame, Rx_FrameSize);
      end
      checks++;
      @(negedge Clk);
      if (useRst) Rst = 1'b0;
      else        RxEN = 1'b0;
      @(posedge Clk);
      #2;
      if ({Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow} !== 8'h00) begin
         errors++; $display("FAIL clear_ctrl(%0d): got %b want 00000000", useRst, {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow});
      end
      checks++;
      if ({Rx_Data, Rx_FrameSize} !== 16'h0000) begin
         errors++; $display("FAIL clear_data(%0d): got data=%h size=%0d want 00/0", useRst, Rx_Data, Rx_FrameSize);
      end
      checks++;
      clearCounts();
      idleCycles(3);
      Rst  = 1'b1;
      RxEN = 1'b1;
      idleCycles(12);
      if (eofCnt !== 0) begin errors++; $display("FAIL clear_no_eof(%0d): got %0d want 0", useRst, eofCnt); end
      checks++;
   endtask

   initial begin
      clearCounts();
      test_reset();
      test_flag_timing();
      test_single_byte();
      test_stuffing();
      test_abort();
      test_frame_error();
      test_back_to_back();
      test_byte_limit();
      test_mid_clear(1'b1);
      test_mid_clear(1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
